// File: rtl/pool_pkg.sv
// Shared types and FP32 constants for the pooling layer.
package pool_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;

   localparam logic MODE_AVG = 1'b0;
   localparam logic MODE_MAX = 1'b1;

   localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
   localparam logic [31:0] FP_POS_ZERO = 32'h00000000;
   localparam logic [31:0] FP_POS_INF  = 32'h7F800000;
   localparam logic [31:0] FP_NEG_INF  = 32'hFF800000;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/pool_accum.sv
// One FP32 combine step: add (RNE) or max of accumulator and pixel,
// with denormal flush, overflow saturation and canonical NaN.
module pool_accum
   import pool_pkg::*;
(
   input  logic        mode,
   input  logic        first,
   input  logic [31:0] acc,
   input  logic [31:0] pix,
   output logic [31:0] result
);

   logic [31:0] p;
   logic        p_nan, a_nan, p_inf, a_inf, p_zero, a_zero;
   logic [31:0] add_res, max_res, big, sml;
   logic [7:0]  d;
   logic [26:0] mb, ms0, ms, mask, norm;
   logic [27:0] sum;
   logic        sticky, found, rb, gt, s;
   logic signed [9:0] e;
   logic [4:0]  lz;
   logic [24:0] rnd;

   assign p_nan  = (&pix[30:23]) && (|pix[22:0]);
   assign a_nan  = (&acc[30:23]) && (|acc[22:0]);
   assign p      = (pix[30:23] == 8'd0) ? {pix[31], 31'b0} : pix;
   assign p_inf  = (&p[30:23]) && !p_nan;
   assign a_inf  = (&acc[30:23]) && !a_nan;
   assign p_zero = (p[30:0] == 31'd0);
   assign a_zero = (acc[30:0] == 31'd0);

   always_comb begin
      add_res = FP_POS_ZERO;
      big = acc; sml = p; d = 8'd0; s = 1'b0;
      mb = '0; ms0 = '0; ms = '0; mask = '0; norm = '0; sum = '0;
      sticky = 1'b0; found = 1'b0; rb = 1'b0; lz = '0; rnd = '0; e = '0;
      if (a_nan || p_nan)  add_res = FP_QNAN;
      else if (a_inf && p_inf) add_res = (acc[31] == p[31]) ? acc : FP_QNAN;
      else if (a_inf)      add_res = acc;
      else if (p_inf)      add_res = p;
      else if (a_zero)     add_res = p_zero ? {acc[31] & p[31], 31'b0} : p;
      else if (p_zero)     add_res = acc;
      else begin
         if (acc[30:0] >= p[30:0]) begin big = acc; sml = p; end
         else begin big = p; sml = acc; end
         s   = big[31];
         d   = big[30:23] - sml[30:23];
         mb  = {1'b1, big[22:0], 3'b000};
         ms0 = {1'b1, sml[22:0], 3'b000};
         if (d >= 8'd27) begin
            ms = '0; sticky = 1'b1;
         end else begin
            mask   = (27'd1 << d) - 27'd1;
            ms     = ms0 >> d;
            sticky = |(ms0 & mask);
         end
         ms = ms | {26'b0, sticky};
         e  = $signed({2'b00, big[30:23]});
         if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[27]) begin
               norm = {sum[27:2], sum[1] | sum[0]};
               e    = e + 10'sd1;
            end else norm = sum[26:0];
         end else begin
            norm = mb - ms;
            // Leading-zero count for post-cancellation renormalisation.
            for (int i = 26; i >= 0; i--)
               if (!found) begin
                  if (norm[i]) found = 1'b1;
                  else lz = lz + 5'd1;
               end
            norm = norm << lz;
            e    = e - $signed({5'b0, lz});
         end
         rb  = norm[2] & (norm[1] | norm[0] | norm[3]);
         rnd = {1'b0, norm[26:3]} + {24'b0, rb};
         if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
         end
         if (norm == 27'd0)       add_res = FP_POS_ZERO;
         else if (e >= 10'sd255)  add_res = {s, 8'hFF, 23'b0};
         else if (e <= 10'sd0)    add_res = {s, 31'b0};
         else                     add_res = {s, e[7:0], rnd[22:0]};
      end
   end

   // Strict greater-than on sign/magnitude; +0 and -0 compare equal.
   always_comb begin
      if (p[31] != acc[31]) gt = !p[31] && !(p_zero && a_zero);
      else if (!p[31])      gt = p[30:0] > acc[30:0];
      else                  gt = p[30:0] < acc[30:0];
      max_res = (a_nan || p_nan) ? FP_QNAN : (gt ? p : acc);
   end

   always_comb begin
      if (first)                  result = p_nan ? FP_QNAN : p;
      else if (mode == MODE_MAX)  result = max_res;
      else                        result = add_res;
   end

endmodule

// File: rtl/pool_layer.sv
// KxK stride-K average/max pooling over CH channels, one pixel per cycle,
// one registered output written per window.
module pool_layer
   import pool_pkg::*;
#(
   parameter int SIZE = 10,
   parameter int CH   = 1,
   parameter int K    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic mode,
   input  logic [CH-1:0][SIZE-1:0][SIZE-1:0][31:0] ImageIn,
   output logic [CH-1:0][SIZE/K-1:0][SIZE/K-1:0][31:0] ImageOut,
   output logic busy,
   output logic done
);

   localparam int OS = SIZE / K;
   localparam int SH = clog2(K * K);
   localparam int CW = (CH > 1) ? clog2(CH) : 1;
   localparam int OW = (OS > 1) ? clog2(OS) : 1;
   localparam int KW = clog2(K);
   localparam int RW = clog2(SIZE);

   state_t          state;
   logic            mode_r;
   logic [31:0]     acc, acc_next, pix, div_out;
   logic [CW-1:0]   ch;
   logic [OW-1:0]   orow, ocol;
   logic [KW-1:0]   wr, wc;
   logic [RW-1:0]   row, col;
   logic            first;

   assign row   = RW'(orow * K + wr);
   assign col   = RW'(ocol * K + wc);
   assign pix   = ImageIn[ch][row][col];
   assign first = (wr == '0) && (wc == '0);

   pool_accum u_accum (
      .mode   (mode_r),
      .first  (first),
      .acc    (acc),
      .pix    (pix),
      .result (acc_next)
   );

   // Divide by K*K through the exponent; NaN, inf and zero pass unchanged.
   always_comb begin
      div_out = acc;
      if (mode_r == MODE_AVG && acc[30:23] != 8'hFF && acc[30:23] != 8'h00) begin
         if (acc[30:23] <= 8'(SH)) div_out = {acc[31], 31'b0};
         else                      div_out = {acc[31], acc[30:23] - 8'(SH), acc[22:0]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         mode_r   <= MODE_AVG;
         acc      <= '0;
         ch       <= '0;
         orow     <= '0;
         ocol     <= '0;
         wr       <= '0;
         wc       <= '0;
         ImageOut <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state  <= S_ACCUM;
               busy   <= 1'b1;
               mode_r <= mode;
               ch     <= '0;
               orow   <= '0;
               ocol   <= '0;
               wr     <= '0;
               wc     <= '0;
            end
            S_ACCUM: begin
               acc <= acc_next;
               if (wc == KW'(K - 1)) begin
                  wc <= '0;
                  if (wr == KW'(K - 1)) begin
                     wr    <= '0;
                     state <= S_WRITE;
                  end else wr <= wr + 1'b1;
               end else wc <= wc + 1'b1;
            end
            S_WRITE: begin
               ImageOut[ch][orow][ocol] <= div_out;
               state <= S_ACCUM;
               if (ocol != OW'(OS - 1)) ocol <= ocol + 1'b1;
               else begin
                  ocol <= '0;
                  if (orow != OW'(OS - 1)) orow <= orow + 1'b1;
                  else begin
                     orow <= '0;
                     if (ch != CW'(CH - 1)) ch <= ch + 1'b1;
                     else begin
                        ch    <= '0;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_layer.sv
// Directed bench for pool_layer: small 4x4 K=2 instance and 8x8x2 K=4 instance.
module tb_pool_layer;
   import pool_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start4 = 1'b0, start8 = 1'b0, mode = 1'b0;
   logic [0:0][3:0][3:0][31:0] img4 = '0;
   logic [0:0][1:0][1:0][31:0] out4;
   logic [1:0][7:0][7:0][31:0] img8 = '0;
   logic [1:0][1:0][1:0][31:0] out8;
   logic busy4, done4, busy8, done8;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] q[$];
   int de, dc, bc;

   always #5 clk = ~clk;

   pool_layer #(.SIZE(4), .CH(1), .K(2)) u_small (
      .clk(clk), .reset(reset), .start(start4), .mode(mode),
      .ImageIn(img4), .ImageOut(out4), .busy(busy4), .done(done4));

   pool_layer #(.SIZE(8), .CH(2), .K(4)) u_big (
      .clk(clk), .reset(reset), .start(start8), .mode(mode),
      .ImageIn(img8), .ImageOut(out8), .busy(busy8), .done(done8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Fill one 2x2 window of the small image and push its expected output.
   task automatic set_win(input int w, input logic [31:0] a, b, c, d, exp);
      int r0, c0;
      r0 = (w / 2) * 2;
      c0 = (w % 2) * 2;
      img4[0][r0][c0]     = a;
      img4[0][r0][c0+1]   = b;
      img4[0][r0+1][c0]   = c;
      img4[0][r0+1][c0+1] = d;
      q.push_back(exp);
   endtask

   task automatic load_avg_mix();
      set_win(0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40200000);
      set_win(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h34000000, 32'h3F400000);
      set_win(2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h34400000, 32'h3F400001);
      set_win(3, 32'h3F800000, 32'hBF000000, 32'h3E800000, 32'h3E800000, 32'h3E800000);
   endtask

   task automatic load_ones();
      for (int w = 0; w < 4; w++)
         set_win(w, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
   endtask

   task automatic check_small(input string tag);
      logic [31:0] exp;
      for (int w = 0; w < 4; w++) begin
         exp = q.pop_front();
         chk($sformatf("%s_w%0d", tag, w), out4[0][w/2][w%2], exp);
      end
   endtask

   function automatic logic [31:0] int_to_fp(input int n);
      logic [31:0] r;
      int e;
      r = '0;
      if (n > 0) begin
         e = 0;
         for (int i = 0; i < 31; i++) if ((n >> i) != 0) e = i;
         r[30:23] = 8'(127 + e);
         r[22:0]  = 23'(n << (23 - e));
      end
      return r;
   endfunction

   // One pass: start sampled at edge 0, edges counted after it.
   task automatic run_pass(input bit sel, input logic m, input int abort_at, input int poke_at,
                           output int done_edge, output int dcount, output int busy_cnt);
      int n;
      n = 0; done_edge = -1; dcount = 0; busy_cnt = 0;
      @(negedge clk);
      mode = m;
      if (sel) start8 = 1'b1; else start4 = 1'b1;
      @(posedge clk); #1;
      if (sel ? busy8 : busy4) busy_cnt++;
      @(negedge clk);
      start4 = 1'b0; start8 = 1'b0;
      while (n < 400) begin
         if (abort_at > 0 && n == abort_at - 1) reset = 1'b1;
         if (poke_at > 0 && n == poke_at - 1) begin
            mode = ~m;
            if (sel) start8 = 1'b1; else start4 = 1'b1;
         end
         if (poke_at > 0 && n == poke_at) begin
            mode = m; start4 = 1'b0; start8 = 1'b0;
         end
         @(posedge clk); n++; #1;
         if (sel ? done8 : done4) begin
            dcount++;
            if (done_edge < 0) done_edge = n;
         end
         if (sel ? busy8 : busy4) busy_cnt++;
         @(negedge clk);
         if (done_edge >= 0 && n >= done_edge + 3) break;
         if (abort_at > 0 && n >= abort_at + 25) break;
      end
      reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy4}, 32'd0);
      chk("rst_done", {31'b0, done4}, 32'd0);
      chk("rst_out4", out4[0][1][1], 32'h0);
      chk("rst_out8", out8[1][1][1], 32'h0);
      @(negedge clk);
      reset = 1'b0;

      load_ones();
      run_pass(1'b0, MODE_AVG, 0, 0, de, dc, bc);
      chk("ones_done_edge", de, 20);
      chk("ones_done_cnt", dc, 1);
      chk("ones_busy_cycles", bc, 20);
      check_small("ones");

      load_avg_mix();
      run_pass(1'b0, MODE_AVG, 0, 0, de, dc, bc);
      check_small("avg_mix");

      set_win(0, 32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 32'h40600000);
      set_win(1, 32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0000000, 32'h00000000);
      set_win(2, 32'h3F800000, 32'h40000000, 32'h7FC00001, 32'h40400000, 32'h7FC00000);
      set_win(3, 32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0A00000, 32'hBF800000);
      run_pass(1'b0, MODE_MAX, 0, 0, de, dc, bc);
      check_small("max_mix");

      set_win(0, 32'h3F800000, 32'h7FC00001, 32'h40000000, 32'h40400000, 32'h7FC00000);
      set_win(1, 32'h00800000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
      set_win(2, 32'h80800000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
      set_win(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      run_pass(1'b0, MODE_AVG, 0, 0, de, dc, bc);
      check_small("avg_special");

      set_win(0, 32'h80000000, 32'h00000000, 32'h80000005, 32'h00000001, 32'h80000000);
      set_win(1, 32'hFF800000, 32'hC0000000, 32'hFF800000, 32'hC0400000, 32'hC0000000);
      set_win(2, 32'h7F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h7F800000);
      set_win(3, 32'h00400000, 32'hBF800000, 32'h80000001, 32'hBF000000, 32'h00000000);
      run_pass(1'b0, MODE_MAX, 0, 0, de, dc, bc);
      check_small("max_special");

      // Abort at edge 7: outputs cleared, no done pulse.
      load_ones();
      run_pass(1'b0, MODE_AVG, 7, 0, de, dc, bc);
      chk("abort_done_cnt", dc, 0);
      chk("abort_busy", {31'b0, busy4}, 32'd0);
      for (int w = 0; w < 4; w++) chk($sformatf("abort_out_w%0d", w), out4[0][w/2][w%2], 32'h0);
      run_pass(1'b0, MODE_AVG, 0, 0, de, dc, bc);
      chk("restart_done_edge", de, 20);
      chk("restart_done_cnt", dc, 1);
      check_small("restart");

      // Start re-pulsed with mode flipped while busy.
      load_avg_mix();
      run_pass(1'b0, MODE_AVG, 0, 5, de, dc, bc);
      chk("poke_done_edge", de, 20);
      chk("poke_done_cnt", dc, 1);
      chk("poke_busy_cycles", bc, 20);
      check_small("poke");

      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 8; r++)
            for (int x = 0; x < 8; x++) img8[c][r][x] = 32'h3F800000;
      for (int i = 0; i < 8; i++) q.push_back(32'h3F800000);
      run_pass(1'b1, MODE_AVG, 0, 0, de, dc, bc);
      chk("big_done_edge", de, 136);
      chk("big_done_cnt", dc, 1);
      chk("big_busy_cycles", bc, 136);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 2; r++)
            for (int x = 0; x < 2; x++)
               chk($sformatf("big_avg_%0d%0d%0d", c, r, x), out8[c][r][x], q.pop_front());

      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 8; r++)
            for (int x = 0; x < 8; x++) img8[c][r][x] = int_to_fp(c * 64 + r * 8 + x);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 2; r++)
            for (int x = 0; x < 2; x++)
               q.push_back(int_to_fp(c * 64 + (r * 4 + 3) * 8 + x * 4 + 3));
      run_pass(1'b1, MODE_MAX, 0, 0, de, dc, bc);
      chk("big_max_done_edge", de, 136);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 2; r++)
            for (int x = 0; x < 2; x++)
               chk($sformatf("big_max_%0d%0d%0d", c, r, x), out8[c][r][x], q.pop_front());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pool_layer.md
POOL_LAYER -- requirements
Module: pool_layer

Interface
REQ-001 The block SHALL have parameter SIZE, default 10, input image side length; SIZE SHALL be a multiple of K.
REQ-002 The block SHALL have parameter CH, default 1, number of channels pooled independently.
REQ-003 The block SHALL have parameter K, default 2, pooling window side and stride; only 2 and 4 are legal.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  request to pool the current ImageIn; sampled only in IDLE.
REQ-007 The block SHALL have port mode  input  1  0 = average pooling, 1 = max pooling; captured on the start edge.
REQ-008 The block SHALL have port ImageIn  input  32 x [CH][SIZE][SIZE]  FP32 pixels, read live; the driver SHALL hold them stable while busy=1.
REQ-009 The block SHALL have port ImageOut  output  32 x [CH][SIZE/K][SIZE/K]  registered FP32 pooled results.
REQ-010 The block SHALL have port busy  output  1  high in ACCUM and WRITE.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM, WRITE, DONE; IDLE->ACCUM on start=1; ACCUM->WRITE after K*K pixels; WRITE->ACCUM if windows remain, else WRITE->DONE; DONE->IDLE unconditionally.
REQ-013 Scan order SHALL be: channel outermost, then output row, then output column; within a window, row-major.
REQ-014 Each ACCUM cycle SHALL consume exactly one pixel; the first pixel of a window SHALL load the accumulator, not combine with the prior value.
REQ-015 Each window SHALL take K*K+1 cycles; done SHALL be high for exactly one cycle, beginning CH*(SIZE/K)^2*(K*K+1) edges after the edge sampling start.
REQ-016 In WRITE, exactly one ImageOut[c][r][col] SHALL be updated; all other entries SHALL hold their values.
REQ-017 Average mode SHALL use FP32 addition with round-to-nearest-even, then divide by K*K by subtracting log2(K*K) from the exponent.
REQ-017a An exponent underflow on that subtraction SHALL give signed zero.
REQ-018 Max mode SHALL use an FP32 magnitude/sign compare; on equality, including +0 vs -0, the earlier pixel SHALL be kept.
REQ-019 Denormal inputs SHALL be flushed to signed zero; addition overflow SHALL saturate to signed infinity.
REQ-020 Any NaN in a window SHALL produce canonical NaN 32'h7FC00000 in both modes.
REQ-021 start asserted while busy=1 or in DONE SHALL be ignored; a change of mode while busy=1 SHALL have no effect.
REQ-022 start held high continuously SHALL begin a new pass in the cycle after DONE.

Reset
REQ-023 reset=1 SHALL asynchronously force IDLE, busy=0, done=0, all ImageOut entries to 32'h0, and all counters and the accumulator to 0.
REQ-024 Reset mid-operation SHALL abort the pass with no done pulse; the next start SHALL run a full, correct pass.

Structure
REQ-025 Shared package pool_pkg SHALL hold the state enum, the mode constants (MODE_AVG=0, MODE_MAX=1), FP32 constants (canonical NaN, +0, +/-inf), and a constant log2 function.
REQ-026 The FP32 combine step (add-or-max plus NaN/denormal handling) SHALL be one combinational sub-module, pool_accum; counters, the FSM and the final divide SHALL be in pool_layer.

Verification
REQ-027 SIZE=4, CH=1, K=2, avg, all pixels 32'h3F800000 -> all 4 outputs 32'h3F800000; done 20 edges after start; busy high for 20 cycles.
REQ-028 Avg window {1.0, 2.0, 3.0, 4.0} -> 32'h40200000 (2.5); max window {1.0, -2.0, 3.5, 0.5} -> 32'h40600000 (3.5).
REQ-029 SIZE=8, CH=2, K=4, avg, all ones -> 8 outputs 32'h3F800000; done 136 edges after start.
REQ-030 Window containing 32'h7FC00001, in both modes -> 32'h7FC00000; max window {+0, -0, -1.0, -2.0} -> 32'h00000000.
REQ-031 Reset asserted at edge 7 of a pass -> ImageOut all 0, no done pulse; a restart gives the same results as REQ-027.
REQ-032 start pulsed at edge 5 of a pass, with mode toggled -> no effect on timing or results; single done pulse.
